rrag_mem_queue: RTL and testbench

- Decoupling queue between the RrAg stage and the MEM stage.
- Accepts one address-generated micro-op bundle per cycle from RrAg: memory addresses, end addresses, rw codes, opsize, ptcid, eip and opaque control.
- Presents bundles in order to MEM.
- Back-pressures RrAg through a registered full flag. Provides a registered empty flag, which feeds RrAg's latch_empty-style qualification.

---
 rtl/rrag_mem_pkg.sv | 35 +++
 rtl/rrag_mem_queue_if.sv | 56 +++++
 rtl/rrag_q_store.sv | 29 ++
 rtl/rrag_mem_queue.sv | 139 +++++++++++++
 tb/tb_rrag_mem_queue.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rrag_mem_pkg.sv
// Shared definitions for the RrAg -> MEM decoupling queue: field widths,
// rw codes and the packed layout of one queued micro-op bundle.
package rrag_mem_pkg;

    localparam int ADDR_W     = 32;
    localparam int PTCID_W    = 7;
    localparam int RW_W       = 2;
    localparam int OPSIZE_W   = 2;
    localparam int CTRL_W_DEF = 128;

    typedef enum logic [RW_W-1:0] {
        RW_NONE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10,
        RW_RMW   = 2'b11
    } rw_e;

    // Fixed-width part of an entry; the opaque control field is appended
    // below it so its width can stay a per-instance parameter.
    typedef struct packed {
        logic [ADDR_W-1:0]   addr1;
        logic [ADDR_W-1:0]   addr2;
        logic [ADDR_W-1:0]   addr1_end;
        logic [ADDR_W-1:0]   addr2_end;
        logic [RW_W-1:0]     rw1;
        logic [RW_W-1:0]     rw2;
        logic [OPSIZE_W-1:0] opsize;
        logic [PTCID_W-1:0]  ptcid;
        logic [ADDR_W-1:0]   eip;
    } entry_hdr_t;

    localparam int HDR_W   = $bits(entry_hdr_t);
    localparam int ENTRY_W = HDR_W + CTRL_W_DEF;

endpackage

// File: rtl/rrag_mem_queue_if.sv
// Bundle interface between RrAg (master), the queue (slave) and MEM.
interface rrag_mem_queue_if
    import rrag_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CTRL_W = CTRL_W_DEF
);
    // RrAg side
    logic                    valid_in;
    logic [ADDR_W-1:0]       mem_addr1_in;
    logic [ADDR_W-1:0]       mem_addr2_in;
    logic [ADDR_W-1:0]       mem_addr1_end_in;
    logic [ADDR_W-1:0]       mem_addr2_end_in;
    logic [RW_W-1:0]         mem1_rw_in;
    logic [RW_W-1:0]         mem2_rw_in;
    logic [OPSIZE_W-1:0]     opsize_in;
    logic [PTCID_W-1:0]      ptcid_in;
    logic [ADDR_W-1:0]       eip_in;
    logic [CTRL_W-1:0]       ctrl_in;
    logic                    flush;
    logic                    full;
    logic                    afull;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;

    // MEM side
    logic                    mem_stall;
    logic                    valid_out;
    logic [ADDR_W-1:0]       mem_addr1_out;
    logic [ADDR_W-1:0]       mem_addr2_out;
    logic [ADDR_W-1:0]       mem_addr1_end_out;
    logic [ADDR_W-1:0]       mem_addr2_end_out;
    logic [RW_W-1:0]         mem1_rw_out;
    logic [RW_W-1:0]         mem2_rw_out;
    logic [OPSIZE_W-1:0]     opsize_out;
    logic [PTCID_W-1:0]      ptcid_out;
    logic [ADDR_W-1:0]       eip_out;
    logic [CTRL_W-1:0]       ctrl_out;

    modport master (
        output valid_in, mem_addr1_in, mem_addr2_in, mem_addr1_end_in, mem_addr2_end_in,
               mem1_rw_in, mem2_rw_in, opsize_in, ptcid_in, eip_in, ctrl_in, flush, mem_stall,
        input  full, afull, empty, count, valid_out, mem_addr1_out, mem_addr2_out,
               mem_addr1_end_out, mem_addr2_end_out, mem1_rw_out, mem2_rw_out,
               opsize_out, ptcid_out, eip_out, ctrl_out
    );

    modport slave (
        input  valid_in, mem_addr1_in, mem_addr2_in, mem_addr1_end_in, mem_addr2_end_in,
               mem1_rw_in, mem2_rw_in, opsize_in, ptcid_in, eip_in, ctrl_in, flush, mem_stall,
        output full, afull, empty, count, valid_out, mem_addr1_out, mem_addr2_out,
               mem_addr1_end_out, mem_addr2_end_out, mem1_rw_out, mem2_rw_out,
               opsize_out, ptcid_out, eip_out, ctrl_out
    );

endinterface

// File: rtl/rrag_q_store.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port.
module rrag_q_store #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry.
    // NOTE: no reset on the array; contents are only ever read once the
    // occupancy logic marks them valid, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rrag_mem_queue.sv
// RrAg -> MEM decoupling queue. In-order FIFO with registered full/afull/
// empty flags; full depends only on the registered count so mem_stall never
// reaches RrAg's stall path. Head fields are forced to zero while empty.
// Optional macro RRAG_MEM_QUEUE_BYPASS_EN: an empty queue forwards the
// incoming bundle combinationally (0-cycle latency).
module rrag_mem_queue
    import rrag_mem_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input logic             clk,
    input logic             clr,
    rrag_mem_queue_if.slave qif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int W     = HDR_W + CTRL_W;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             empty_q, empty_d;

    logic             enq;
    logic             deq;
    logic             byp_take;
    logic             head_valid;
    entry_hdr_t       in_hdr;
    entry_hdr_t       head_hdr;
    logic [W-1:0]     in_entry;
    logic [W-1:0]     rd_entry;
    logic [W-1:0]     head_entry;

    assign in_hdr = '{
        addr1:     qif.mem_addr1_in,
        addr2:     qif.mem_addr2_in,
        addr1_end: qif.mem_addr1_end_in,
        addr2_end: qif.mem_addr2_end_in,
        rw1:       qif.mem1_rw_in,
        rw2:       qif.mem2_rw_in,
        opsize:    qif.opsize_in,
        ptcid:     qif.ptcid_in,
        eip:       qif.eip_in
    };
    assign in_entry = {in_hdr, qif.ctrl_in};

`ifdef RRAG_MEM_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass     = empty_q & qif.valid_in & ~qif.flush;
    assign byp_take   = bypass & ~qif.mem_stall;
    assign head_valid = bypass | ~empty_q;
    assign head_entry = bypass ? in_entry : (rd_entry & {W{~empty_q}});
`else
    assign byp_take   = 1'b0;
    assign head_valid = ~empty_q;
    assign head_entry = rd_entry & {W{~empty_q}};
`endif

    // A bypassed bundle consumed by MEM this cycle is never written.
    assign enq = qif.valid_in & ~full_q & ~qif.flush & ~byp_take;
    assign deq = ~empty_q & ~qif.mem_stall & ~qif.flush;

    rrag_q_store #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_store (
        .clk     (clk),
        .we_i    (enq),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Next pointers, occupancy and flags; flush overrides everything.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (qif.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        afull_d = (count_d >= CNT_W'(AFULL_LVL));
        empty_d = (count_d == '0);
    end

    // State registers with asynchronous clear.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
        end
    end

    assign head_hdr = head_entry[W-1:CTRL_W];

    assign qif.full              = full_q;
    assign qif.afull             = afull_q;
    assign qif.empty             = empty_q;
    assign qif.count             = count_q;
    assign qif.valid_out         = head_valid;
    assign qif.mem_addr1_out     = head_hdr.addr1;
    assign qif.mem_addr2_out     = head_hdr.addr2;
    assign qif.mem_addr1_end_out = head_hdr.addr1_end;
    assign qif.mem_addr2_end_out = head_hdr.addr2_end;
    assign qif.mem1_rw_out       = head_hdr.rw1;
    assign qif.mem2_rw_out       = head_hdr.rw2;
    assign qif.opsize_out        = head_hdr.opsize;
    assign qif.ptcid_out         = head_hdr.ptcid;
    assign qif.eip_out           = head_hdr.eip;
    assign qif.ctrl_out          = head_entry[CTRL_W-1:0];

endmodule

// File: tb/tb_rrag_mem_queue.sv
// Directed bench for rrag_mem_queue (DEPTH=4). Main scenarios target the
// default build; the zero-latency scenario is compiled in with
// RRAG_MEM_QUEUE_BYPASS_EN.
module tb_rrag_mem_queue;
    import rrag_mem_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CTRL_W = 128;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;

    rrag_mem_queue_if #(.DEPTH(DEPTH), .CTRL_W(CTRL_W)) qif ();

    rrag_mem_queue #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .AFULL_LVL(DEPTH - 1)) dut (
        .clk (clk),
        .clr (clr),
        .qif (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] eip_of(input int k);
        return 32'h0040_0000 + k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input int k);
        qif.mem_addr1_in     = 32'h1000_0000 + k;
        qif.mem_addr2_in     = 32'h2000_0000 + k;
        qif.mem_addr1_end_in = 32'h1000_0003 + k;
        qif.mem_addr2_end_in = 32'h2000_0007 + k;
        qif.mem1_rw_in       = RW_READ;
        qif.mem2_rw_in       = RW_WRITE;
        qif.opsize_in        = k[1:0];
        qif.ptcid_in         = k[6:0];
        qif.eip_in           = eip_of(k);
        qif.ctrl_in          = {4{k}};
    endtask

    task automatic test_reset();
        clr = 1'b0;
        qif.valid_in = 1'b0; qif.flush = 1'b0; qif.mem_stall = 1'b0;
        set_bundle(0);
        #1 clr = 1'b1;
        #1;
        n_cmp++; if (qif.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", qif.empty); end
        n_cmp++; if (qif.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", qif.full); end
        n_cmp++; if (qif.afull !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", qif.afull); end
        n_cmp++; if (qif.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", qif.valid_out); end
        n_cmp++; if (qif.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", qif.count); end
        n_cmp++; if (qif.eip_out !== 32'h0) begin n_err++; $display("FAIL reset_eip_gated: got %h want 0", qif.eip_out); end
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [229:0] got, want;
        qif.mem_addr1_in     = 32'h0001_2340;
        qif.mem_addr2_in     = 32'hCAFE_0000;
        qif.mem_addr1_end_in = 32'h0001_2343;
        qif.mem_addr2_end_in = 32'hCAFE_0007;
        qif.mem1_rw_in       = RW_RMW;
        qif.mem2_rw_in       = RW_NONE;
        qif.opsize_in        = 2'b10;
        qif.ptcid_in         = 7'h15;
        qif.eip_in           = 32'h0040_1000;
        qif.ctrl_in          = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        qif.valid_in         = 1'b1;
        qif.mem_stall        = 1'b0;
        #1;
        n_cmp++; if (qif.valid_out !== 1'b0) begin n_err++; $display("FAIL single_no_comb_path: got %b want 0", qif.valid_out); end
        tick();
        qif.valid_in = 1'b0;
        set_bundle(99);
        n_cmp++; if (qif.valid_out !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", qif.valid_out); end
        n_cmp++; if (qif.mem_addr1_out !== 32'h0001_2340) begin n_err++; $display("FAIL single_addr1: got %h want 00012340", qif.mem_addr1_out); end
        n_cmp++; if (qif.ptcid_out !== 7'h15) begin n_err++; $display("FAIL single_ptcid: got %h want 15", qif.ptcid_out); end
        n_cmp++; if (qif.eip_out !== 32'h0040_1000) begin n_err++; $display("FAIL single_eip: got %h want 00401000", qif.eip_out); end
        got  = {qif.mem_addr2_out, qif.mem_addr1_end_out, qif.mem_addr2_end_out,
                qif.mem1_rw_out, qif.mem2_rw_out, qif.opsize_out, qif.ctrl_out};
        want = {32'hCAFE_0000, 32'h0001_2343, 32'hCAFE_0007, 2'b11, 2'b00, 2'b10,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        n_cmp++; if (got !== want) begin n_err++; $display("FAIL single_fields: got %h want %h", got, want); end
        n_cmp++; if (qif.count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", qif.count); end
        tick();
        n_cmp++; if (qif.empty !== 1'b1) begin n_err++; $display("FAIL single_drain_empty: got %b want 1", qif.empty); end
        n_cmp++; if (qif.valid_out !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %b want 0", qif.valid_out); end
        n_cmp++; if (qif.eip_out !== 32'h0) begin n_err++; $display("FAIL single_drain_gated: got %h want 0", qif.eip_out); end
    endtask

    task automatic test_full_stall();
        qif.mem_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_bundle(i);
            qif.valid_in = 1'b1;
            tick();
            n_cmp++; if (qif.count !== 3'(i)) begin n_err++; $display("FAIL fill_count_%0d: got %0d want %0d", i, qif.count, i); end
            n_cmp++; if (qif.afull !== (i >= 3)) begin n_err++; $display("FAIL fill_afull_%0d: got %b want %b", i, qif.afull, i >= 3); end
            n_cmp++; if (qif.full !== (i == 4)) begin n_err++; $display("FAIL fill_full_%0d: got %b want %b", i, qif.full, i == 4); end
        end
        set_bundle(5);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (qif.count !== 3'd4) begin n_err++; $display("FAIL hold_count: got %0d want 4", qif.count); end
            n_cmp++; if (qif.eip_out !== eip_of(1)) begin n_err++; $display("FAIL hold_head: got %h want %h", qif.eip_out, eip_of(1)); end
        end
        qif.mem_stall = 1'b0;
        #1;
        n_cmp++; if (qif.eip_out !== eip_of(1)) begin n_err++; $display("FAIL order_1: got %h want %h", qif.eip_out, eip_of(1)); end
        tick();
        n_cmp++; if (qif.count !== 3'd3) begin n_err++; $display("FAIL refuse_count: got %0d want 3", qif.count); end
        n_cmp++; if (qif.eip_out !== eip_of(2)) begin n_err++; $display("FAIL order_2: got %h want %h", qif.eip_out, eip_of(2)); end
        tick();
        qif.valid_in = 1'b0;
        n_cmp++; if (qif.count !== 3'd3) begin n_err++; $display("FAIL accept5_count: got %0d want 3", qif.count); end
        n_cmp++; if (qif.eip_out !== eip_of(3)) begin n_err++; $display("FAIL order_3: got %h want %h", qif.eip_out, eip_of(3)); end
        tick();
        n_cmp++; if (qif.eip_out !== eip_of(4)) begin n_err++; $display("FAIL order_4: got %h want %h", qif.eip_out, eip_of(4)); end
        tick();
        n_cmp++; if (qif.eip_out !== eip_of(5)) begin n_err++; $display("FAIL order_5: got %h want %h", qif.eip_out, eip_of(5)); end
        tick();
        n_cmp++; if (qif.empty !== 1'b1) begin n_err++; $display("FAIL order_drained: got %b want 1", qif.empty); end
    endtask

    task automatic test_back_to_back();
        int  sent;
        int  exp_k;
        logic accept;
        logic streaming;
        qif.mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_bundle(100 + i);
            qif.valid_in = 1'b1;
            tick();
        end
        n_cmp++; if (qif.full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b want 1", qif.full); end
        qif.mem_stall = 1'b0;
        sent  = 4;
        exp_k = 100;
        for (int c = 0; c < 200; c++) begin
            if (sent < 20) begin
                set_bundle(100 + sent);
                qif.valid_in = 1'b1;
            end else begin
                qif.valid_in = 1'b0;
            end
            #1;
            streaming = qif.valid_in;
            accept    = qif.valid_in & ~qif.full;
            if (qif.valid_out) begin
                n_cmp++; if (qif.eip_out !== eip_of(exp_k)) begin n_err++; $display("FAIL b2b_order: got %h want %h", qif.eip_out, eip_of(exp_k)); end
                exp_k++;
            end
            tick();
            if (accept) sent++;
            if (streaming) begin
                n_cmp++; if (qif.count !== 3'd3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", qif.count); end
            end
            if (sent == 20 && qif.empty) break;
        end
        qif.valid_in = 1'b0;
        n_cmp++; if (exp_k !== 120) begin n_err++; $display("FAIL b2b_delivered: got %0d want 120", exp_k); end
        n_cmp++; if (qif.empty !== 1'b1) begin n_err++; $display("FAIL b2b_drained: got %b want 1", qif.empty); end
    endtask

    task automatic test_flush();
        qif.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_bundle(200 + i);
            qif.valid_in = 1'b1;
            tick();
        end
        n_cmp++; if (qif.afull !== 1'b1) begin n_err++; $display("FAIL preflush_afull: got %b want 1", qif.afull); end
        set_bundle(250);
        qif.flush = 1'b1;
        tick();
        qif.flush    = 1'b0;
        qif.valid_in = 1'b0;
        n_cmp++; if (qif.count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", qif.count); end
        n_cmp++; if (qif.empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", qif.empty); end
        n_cmp++; if (qif.afull !== 1'b0) begin n_err++; $display("FAIL flush_afull: got %b want 0", qif.afull); end
        qif.mem_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (qif.valid_out !== 1'b0) begin n_err++; $display("FAIL flush_dropped: got %b want 0", qif.valid_out); end
        end
        set_bundle(260);
        qif.valid_in = 1'b1;
        tick();
        qif.valid_in = 1'b0;
        n_cmp++; if (qif.eip_out !== eip_of(260)) begin n_err++; $display("FAIL postflush_head: got %h want %h", qif.eip_out, eip_of(260)); end
        tick();
    endtask

    task automatic test_clr_async();
        qif.mem_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_bundle(300 + i);
            qif.valid_in = 1'b1;
            tick();
        end
        qif.valid_in = 1'b0;
        n_cmp++; if (qif.count !== 3'd2) begin n_err++; $display("FAIL preclr_count: got %0d want 2", qif.count); end
        #3 clr = 1'b1;
        #1;
        n_cmp++; if (qif.valid_out !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", qif.valid_out); end
        n_cmp++; if (qif.full !== 1'b0) begin n_err++; $display("FAIL clr_full: got %b want 0", qif.full); end
        n_cmp++; if (qif.count !== 3'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", qif.count); end
        n_cmp++; if (qif.empty !== 1'b1) begin n_err++; $display("FAIL clr_empty: got %b want 1", qif.empty); end
        #1 clr = 1'b0;
        qif.mem_stall = 1'b0;
        tick();
        n_cmp++; if (qif.valid_out !== 1'b0) begin n_err++; $display("FAIL postclr_valid: got %b want 0", qif.valid_out); end
    endtask

`ifdef RRAG_MEM_QUEUE_BYPASS_EN
    task automatic test_bypass();
        set_bundle(7);
        qif.eip_in    = 32'hDEAD_BEEF;
        qif.mem_stall = 1'b0;
        qif.valid_in  = 1'b1;
        #1;
        n_cmp++; if (qif.valid_out !== 1'b1) begin n_err++; $display("FAIL bypass_valid: got %b want 1", qif.valid_out); end
        n_cmp++; if (qif.eip_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_eip: got %h want deadbeef", qif.eip_out); end
        n_cmp++; if (qif.count !== 3'd0) begin n_err++; $display("FAIL bypass_count: got %0d want 0", qif.count); end
        tick();
        qif.valid_in = 1'b0;
        n_cmp++; if (qif.count !== 3'd0) begin n_err++; $display("FAIL bypass_not_written: got %0d want 0", qif.count); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
`ifdef RRAG_MEM_QUEUE_BYPASS_EN
        test_bypass();
`else
        test_single();
        test_full_stall();
        test_back_to_back();
        test_flush();
        test_clr_async();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
